// File: rtl/if_prefetch.sv
// if_prefetch: instruction fetch unit with a small prefetch queue.
//
// A fetch FSM (IDLE / WAIT / DISCARD) keeps at most one instruction-memory
// request outstanding. Returned words are pushed, together with their
// address, into a DEPTH-entry FIFO whose head is presented to decode.
// A jmp flushes the queue and redirects the fetch PC. If a request is still
// in flight when the jmp arrives, its data is dropped when it returns.
//
// Parameters:
//   XLEN     - address width
//   DEPTH    - prefetch queue entries (power of two, >= 2)
//   RESET_PC - first fetch address after reset
//
// Ports:
//   clk           in   clock, all state updates on posedge
//   rst           in   synchronous active-high reset
//   jmp           in   redirect request
//   new_inst_addr in   redirect target, sampled when jmp=1
//   if_stall      in   downstream holds the current instruction
//   imem_req      out  instruction memory request
//   imem_addr     out  request address
//   imem_ack      in   request complete, imem_rdata valid this cycle
//   imem_rdata    in   fetched instruction word
//   inst_valid    out  queue head valid
//   inst_addr     out  address of the head instruction
//   inst          out  head instruction word
//   flush_cnt     out  count of jmp cycles (only with IF_PREFETCH_PERF_EN)
//
// Build option: define IF_PREFETCH_PERF_EN to add the flush_cnt counter.

module if_prefetch #(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jmp,
    input  logic [XLEN-1:0] new_inst_addr,
    input  logic            if_stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
`ifdef IF_PREFETCH_PERF_EN
    output logic [31:0]     flush_cnt,
`endif
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_addr,
    output logic [31:0]     inst
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   cnt_q;
    logic            push, pop;

    logic [XLEN-1:0] addr_mem [DEPTH];
    logic [31:0]     data_mem [DEPTH];

    // Queue head; outputs read as zero while the queue is empty.
    assign inst_valid = (cnt_q != '0);
    assign inst_addr  = inst_valid ? addr_mem[rd_ptr_q] : '0;
    assign inst       = inst_valid ? data_mem[rd_ptr_q] : 32'h0;

    // A redirect suppresses the pop: the head is being flushed anyway.
    assign pop = inst_valid && !if_stall && !jmp;

    // Fetch FSM next-state, request and push control.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        imem_req  = 1'b0;
        imem_addr = addr_q;
        push      = 1'b0;

        case (state_q)
            S_IDLE: begin
                imem_addr = pc_q;
                if (jmp) begin
                    pc_d = new_inst_addr;
                end else if ((cnt_q - CW'(pop)) < CW'(DEPTH)) begin
                    // Room is reserved here, so the eventual push never overflows.
                    imem_req = 1'b1;
                    addr_d   = pc_q;
                    if (imem_ack) begin
                        push = 1'b1;
                        pc_d = pc_q + XLEN'(4);
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                imem_req = 1'b1;
                if (jmp) begin
                    pc_d    = new_inst_addr;
                    state_d = imem_ack ? S_IDLE : S_DISCARD;
                end else if (imem_ack) begin
                    push    = 1'b1;
                    pc_d    = pc_q + XLEN'(4);
                    state_d = S_IDLE;
                end
            end
            S_DISCARD: begin
                imem_req = 1'b1;
                if (jmp) begin
                    pc_d = new_inst_addr;
                end
                // The stale request completes here even under a new jmp;
                // waiting for another ack would never terminate.
                if (imem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (rst) begin
            imem_req = 1'b0;
        end
    end

    // FSM, PC and queue control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            if (jmp) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                cnt_q <= cnt_q + CW'(push) - CW'(pop);
            end
        end
    end

    // Queue storage; no reset needed since the head is masked when empty.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            addr_mem[wr_ptr_q] <= imem_addr;
            data_mem[wr_ptr_q] <= imem_rdata;
        end
    end

`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] flush_cnt_q;

    // Counts redirect cycles, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt_q <= 32'h0;
        end else if (jmp) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// Directed testbench for if_prefetch (XLEN=32, DEPTH=4, RESET_PC=0).
// Inputs change on the falling edge; outputs are checked shortly after,
// before the next rising edge. Returned memory words are addr ^ KEY.

module tb_if_prefetch;

    localparam logic [31:0] KEY = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        jmp;
    logic [31:0] new_inst_addr;
    logic        if_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_addr;
    logic [31:0] inst;
`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] flush_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    if_prefetch #(
        .XLEN    (32),
        .DEPTH   (4),
        .RESET_PC(32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .jmp          (jmp),
        .new_inst_addr(new_inst_addr),
        .if_stall     (if_stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
`ifdef IF_PREFETCH_PERF_EN
        .flush_cnt    (flush_cnt),
`endif
        .inst_valid   (inst_valid),
        .inst_addr    (inst_addr),
        .inst         (inst)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus; returns 2 time units after the falling edge.
    task automatic cyc(input logic ack, input logic stall, input logic j,
                       input logic [31:0] tgt);
        @(negedge clk);
        rst           = 1'b0;
        imem_ack      = ack;
        if_stall      = stall;
        jmp           = j;
        new_inst_addr = tgt;
        #1;
        imem_rdata = imem_addr ^ KEY;
        #1;
    endtask

    // Reset across one rising edge; returns just after it with rst still high.
    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        imem_ack   = 1'b0;
        if_stall   = 1'b0;
        jmp        = 1'b0;
        imem_rdata = 32'h0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %0b want 0", imem_req); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", inst_valid); end
        n_checks++; if (inst_addr !== 32'h0) begin n_fail++; $display("FAIL reset_inst_addr got %h want 0", inst_addr); end
        n_checks++; if (inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst got %h want 0", inst); end
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL post_reset_req got %0b want 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL post_reset_addr got %h want 0", imem_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL stream_c1_valid got %0b want 0", inst_valid); end
        n_checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin n_fail++; $display("FAIL stream_c1_req got %0b/%h want 1/0", imem_req, imem_addr); end
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h0);
            n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %0b want 1", i, inst_valid); end
            n_checks++; if (inst_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_addr[%0d] got %h want %h", i, inst_addr, 32'(4 * i)); end
            n_checks++; if (inst !== (32'(4 * i) ^ KEY)) begin n_fail++; $display("FAIL stream_inst[%0d] got %h want %h", i, inst, 32'(4 * i) ^ KEY); end
            n_checks++; if (imem_addr !== 32'(4 * (i + 1))) begin n_fail++; $display("FAIL stream_req_addr[%0d] got %h want %h", i, imem_addr, 32'(4 * (i + 1))); end
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 32'h0);
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL fill_req[%0d] got %0b/%h want 1/%h", i, imem_req, imem_addr, 32'(4 * i)); end
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 32'h0);
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL full_req[%0d] got %0b want 0", i, imem_req); end
            n_checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'h0) begin n_fail++; $display("FAIL full_head[%0d] got %0b/%h want 1/0", i, inst_valid, inst_addr); end
        end
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++; if (inst_addr !== 32'h0) begin n_fail++; $display("FAIL release_head got %h want 0", inst_addr); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_fail++; $display("FAIL release_req got %0b/%h want 1/10", imem_req, imem_addr); end
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        n_checks++; if (inst_addr !== 32'h4 || inst !== (32'h4 ^ KEY)) begin n_fail++; $display("FAIL after_pop_head got %h/%h want 4/%h", inst_addr, inst, 32'h4 ^ KEY); end
    endtask

    task automatic test_jmp_wait();
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'h100);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL jw_hold0 got %0b/%h want 1/0", imem_req, imem_addr); end
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL jw_hold1 got %0b/%h want 1/0", imem_req, imem_addr); end
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL jw_ack_addr got %h want 0", imem_addr); end
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL jw_dropped got %0b want 0", inst_valid); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL jw_redirect got %0b/%h want 1/100", imem_req, imem_addr); end
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        n_checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'h100 || inst !== (32'h100 ^ KEY)) begin n_fail++; $display("FAIL jw_head got %0b/%h/%h want 1/100/%h", inst_valid, inst_addr, inst, 32'h100 ^ KEY); end
    endtask

    task automatic test_jmp_ack();
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 32'h40);
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_jmp_req got %0b want 0", imem_req); end
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        n_checks++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL idle_jmp_target got %h want 40", imem_addr); end
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        n_checks++; if (inst_addr !== 32'h40 || imem_addr !== 32'h44) begin n_fail++; $display("FAIL ja_pre got %h/%h want 40/44", inst_addr, imem_addr); end
        cyc(1'b1, 1'b1, 1'b1, 32'h200);
        n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL ja_valid_before got %0b want 1", inst_valid); end
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL ja_flushed got %0b want 0", inst_valid); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL ja_next_req got %0b/%h want 1/200", imem_req, imem_addr); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        n_checks++; if (imem_addr !== 32'h8 || inst_valid !== 1'b1) begin n_fail++; $display("FAIL rw_pre got %h/%0b want 8/1", imem_addr, inst_valid); end
        do_reset();
        n_checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL rw_after got %0b/%0b want 0/0", inst_valid, imem_req); end
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rw_restart got %0b/%h want 1/0", imem_req, imem_addr); end
    endtask

`ifdef IF_PREFETCH_PERF_EN
    task automatic test_perf();
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++; if (flush_cnt !== 32'd0) begin n_fail++; $display("FAIL perf_zero got %0d want 0", flush_cnt); end
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 32'h10);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++; if (flush_cnt !== 32'd5) begin n_fail++; $display("FAIL perf_five got %0d want 5", flush_cnt); end
        do_reset();
        n_checks++; if (flush_cnt !== 32'd0) begin n_fail++; $display("FAIL perf_reset got %0d want 0", flush_cnt); end
    endtask
`endif

    initial begin
        rst           = 1'b1;
        jmp           = 1'b0;
        new_inst_addr = 32'h0;
        if_stall      = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
        test_reset();
        test_stream();
        test_fill();
        test_jmp_wait();
        test_jmp_ack();
        test_reset_mid_wait();
`ifdef IF_PREFETCH_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
